pwm11_capture: RTL and testbench

PWM capture block: the receive side of the 11-bit PWM generator. It samples an asynchronous PWM waveform and measures the high time and period of each complete cycle. It reports duty on the same 11-bit scale the generator uses, so a capture of a generator output with duty D reads back D with a period of 2048. It sits on loop-back and motor-feedback paths, and flags a stuck-high or stuck-low line through a timeout.

---
 rtl/pwm11_capture.sv | 158 +++++++++++++++
 tb/tb_pwm11_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm11_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input, with stuck-line timeout.
// Optional 3-sample glitch filter enabled by defining PWM_CAPT_GLITCH_FILTER_EN.
module pwm11_capture #(
   parameter int unsigned TIMEOUT = 4095
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pwm_in,
   output logic [10:0] duty,
   output logic [11:0] period,
   output logic        vld,
   output logic        timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [11:0] CNT_MAX = '1;
   localparam logic [11:0] TO_CNT  = 12'(TIMEOUT);

   state_t      state, state_n;
   logic        s1, s2, lvl, hist;
   logic        rise, fall;
   logic [11:0] per_cnt, hi_cnt;
   logic        to_done, to_hit, publish, capture;
   logic        pend_vld, pend_to;
   logic [10:0] pend_duty;
   logic [11:0] pend_period;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= pwm_in;
         s2 <= s1;
      end
   end

`ifdef PWM_CAPT_GLITCH_FILTER_EN
   logic [1:0] sh;
   logic       filt_q;

   // Level follows s2 only once s2 and the two previous samples agree; otherwise it holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh     <= '0;
         filt_q <= 1'b0;
      end else begin
         sh     <= {sh[0], s2};
         filt_q <= lvl;
      end
   end

   always_comb begin
      lvl = filt_q;
      if ((s2 == sh[0]) && (s2 == sh[1]))
         lvl = s2;
   end
`else
   always_comb lvl = s2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hist <= 1'b0;
      else
         hist <= lvl;
   end

   always_comb begin
      rise = lvl & ~hist;
      fall = ~lvl & hist;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   // to_done suppresses repeated strobes while per_cnt sits at or above TIMEOUT in IDLE.
   always_comb begin
      state_n = state;
      publish = 1'b0;
      capture = 1'b0;
      to_hit  = (per_cnt == TO_CNT) && !rise && !to_done;
      if (rise) begin
         state_n = HIGH;
         publish = (state == LOW);
      end else if (to_hit) begin
         state_n = IDLE;
      end else if (fall && (state == HIGH)) begin
         state_n = LOW;
         capture = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
         to_done <= 1'b0;
      end else begin
         if (rise)
            per_cnt <= 12'd1;
         else if (per_cnt != CNT_MAX)
            per_cnt <= per_cnt + 12'd1;
         if (capture)
            hi_cnt <= per_cnt;
         if (rise)
            to_done <= 1'b0;
         else if (to_hit)
            to_done <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_vld    <= 1'b0;
         pend_duty   <= '0;
         pend_period <= '0;
         pend_to     <= 1'b0;
      end else begin
         pend_vld <= publish | to_hit;
         if (publish) begin
            pend_duty   <= hi_cnt[11] ? 11'h7FF : hi_cnt[10:0];
            pend_period <= per_cnt;
            pend_to     <= 1'b0;
         end else if (to_hit) begin
            pend_duty   <= lvl ? 11'h7FF : 11'h000;
            pend_period <= '0;
            pend_to     <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty    <= '0;
         period  <= '0;
         vld     <= 1'b0;
         timeout <= 1'b0;
      end else begin
         vld <= pend_vld;
         if (pend_vld) begin
            duty    <= pend_duty;
            period  <= pend_period;
            timeout <= pend_to;
         end
      end
   end

endmodule

// File: tb/tb_pwm11_capture.sv
// Directed self-checking bench for pwm11_capture (default TIMEOUT and TIMEOUT=100 instances).
module tb_pwm11_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pwm1, pwm2;
   logic [10:0] duty1, duty2;
   logic [11:0] period1, period2;
   logic        vld1, vld2, to1, to2;

   always #5 clk = ~clk;

   pwm11_capture dut1 (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm1),
      .duty(duty1), .period(period1), .vld(vld1), .timeout(to1)
   );

   pwm11_capture #(.TIMEOUT(100)) dut2 (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm2),
      .duty(duty2), .period(period2), .vld(vld2), .timeout(to2)
   );

   typedef struct {
      int duty;
      int period;
      int to;
      int cyc;
   } ev_t;

   ev_t q1[$];
   ev_t q2[$];
   ev_t m1, m2;
   int  cyc    = 0;
   int  errors = 0;
   int  checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe log, sampled 2 time units after each rising edge.
   always @(posedge clk) begin
      #2;
      if (vld1) begin
         m1.duty = int'(duty1); m1.period = int'(period1); m1.to = int'(to1); m1.cyc = cyc;
         q1.push_back(m1);
      end
      if (vld2) begin
         m2.duty = int'(duty2); m2.period = int'(period2); m2.to = int'(to2); m2.cyc = cyc;
         q2.push_back(m2);
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic ev_t get_ev(input int ch, input int i);
      ev_t e;
      e.duty = -1; e.period = -1; e.to = -1; e.cyc = -1;
      if (ch == 1) begin
         if (i < int'(q1.size())) e = q1[i];
      end else begin
         if (i < int'(q2.size())) e = q2[i];
      end
      return e;
   endfunction

   task automatic chk_ev(input string tag, input int ch, input int i,
                         input int d, input int p, input int t);
      ev_t e;
      e = get_ev(ch, i);
      chk({tag, ".duty"}, e.duty, d);
      chk({tag, ".period"}, e.period, p);
      chk({tag, ".timeout"}, e.to, t);
   endtask

   task automatic hold(input int ch, input logic lvl, input int n);
      if (ch == 1) pwm1 = lvl;
      else         pwm2 = lvl;
      repeat (n) @(negedge clk);
   endtask

   int c0;
   ev_t ev;
   ev_t ev_b;

   initial begin
      rst_n = 1'b0;
      pwm1  = 1'b0;
      pwm2  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.duty", int'(duty1), 0);
      chk("rst.period", int'(period1), 0);
      chk("rst.vld", int'(vld1), 0);
      chk("rst.timeout", int'(to1), 0);
      chk("rst.vld2", int'(vld2), 0);
      rst_n = 1'b1;
      hold(1, 1'b0, 10);

      // Generator waveform 2048/1000: no publish until the second rise.
      q1.delete();
      hold(1, 1'b1, 1000);
      hold(1, 1'b0, 1048);
      chk("gen.no_partial", int'(q1.size()), 0);
      c0 = cyc;
      hold(1, 1'b1, 1000);
      hold(1, 1'b0, 1048);
      hold(1, 1'b1, 1000);
      hold(1, 1'b0, 1048);
      hold(1, 1'b1, 4200);
      chk("gen.count", int'(q1.size()), 4);
      chk_ev("gen0", 1, 0, 1000, 2048, 0);
      chk_ev("gen1", 1, 1, 1000, 2048, 0);
      chk_ev("gen2", 1, 2, 1000, 2048, 0);
      ev = get_ev(1, 0);
      chk("gen.latency", ev.cyc, c0 + 4);
      ev_b = get_ev(1, 1);
      chk("gen.spacing", ev_b.cyc - ev.cyc, 2048);

      // Stuck high, then recovery
      chk_ev("stuckhi", 1, 3, 2047, 0, 1);
      chk("stuckhi.level", int'(to1), 1);
      hold(1, 1'b0, 500);
      hold(1, 1'b1, 300);
      chk("recov.to_held", int'(to1), 1);
      chk("recov.no_vld", int'(q1.size()), 4);
      hold(1, 1'b0, 500);
      hold(1, 1'b1, 10);
      chk("recov.count", int'(q1.size()), 5);
      chk_ev("recov", 1, 4, 300, 800, 0);
      chk("recov.level", int'(to1), 0);

      // Held low from reset
      rst_n = 1'b0;
      pwm1  = 1'b0;
      repeat (2) @(negedge clk);
      q1.delete();
      c0 = cyc;
      rst_n = 1'b1;
      repeat (4200) @(negedge clk);
      chk("stucklo.count", int'(q1.size()), 1);
      chk_ev("stucklo", 1, 0, 0, 0, 1);
      ev = get_ev(1, 0);
      chk("stucklo.cycle", ev.cyc, c0 + 4097);
      repeat (300) @(negedge clk);
      chk("stucklo.once", int'(q1.size()), 1);
      hold(1, 1'b1, 100);
      hold(1, 1'b0, 200);
      hold(1, 1'b1, 50);
      chk("pre_rst.count", int'(q1.size()), 2);
      chk_ev("pre_rst", 1, 1, 100, 300, 0);

      // Reset pulse mid-HIGH: outputs clear asynchronously
      rst_n = 1'b0;
      #1;
      chk("midrst.duty", int'(duty1), 0);
      chk("midrst.period", int'(period1), 0);
      chk("midrst.timeout", int'(to1), 0);
      chk("midrst.vld", int'(vld1), 0);
      @(negedge clk);
      @(negedge clk);
      q1.delete();
      rst_n = 1'b1;
      hold(1, 1'b1, 20);
      hold(1, 1'b0, 300);
      chk("postrst.partial", int'(q1.size()), 0);
      hold(1, 1'b1, 600);
      chk_ev("postrst", 1, 0, 20, 320, 0);

      // Two-cycle glitch inside the low phase counts as a real pulse here
      hold(1, 1'b0, 700);
      hold(1, 1'b1, 2);
      hold(1, 1'b0, 746);
      hold(1, 1'b1, 10);
      chk("glitch.count", int'(q1.size()), 3);
      chk_ev("glitch_a", 1, 1, 600, 1300, 0);
      chk_ev("glitch_b", 1, 2, 2, 748, 0);

      // TIMEOUT=100 with rises landing exactly on the timeout count
      q2.delete();
      for (int i = 0; i < 4; i++) begin
         hold(2, 1'b1, 40);
         hold(2, 1'b0, 60);
      end
      hold(2, 1'b1, 10);
      chk("to100.count", int'(q2.size()), 4);
      for (int i = 0; i < 4; i++)
         chk_ev($sformatf("to100_%0d", i), 2, i, 40, 100, 0);
      chk("to100.level", int'(to2), 0);
      hold(2, 1'b1, 150);
      chk("to100.stuck_count", int'(q2.size()), 5);
      chk_ev("to100_stuck", 2, 4, 2047, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
